// File: rtl/irq_pkg.sv
// Shared encodings for the interrupt controller: FSM states, config register
// addresses and the hazard-unit state that signals interrupt acceptance.
package irq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

  localparam logic [1:0] CFG_ADDR_ENABLE   = 2'd0;
  localparam logic [1:0] CFG_ADDR_PENDING  = 2'd1;
  localparam logic [1:0] CFG_ADDR_EDGE_SEL = 2'd2;
  localparam logic [1:0] CFG_ADDR_GLOBAL   = 2'd3;

  localparam logic [3:0] HCU_STATE_INTERRUPT = 4'h2;

endpackage

// File: rtl/irq_priority_encoder.sv
// Combinational fixed-priority encoder: lowest set request bit wins.
module irq_priority_encoder
  import irq_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [3:0]   index
);

  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i] && !valid) begin
        valid = 1'b1;
        index = 4'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt source block: edge/level capture into pending, masking, priority
// selection and a request/service handshake with the hazard control unit.
module interrupt_controller
  import irq_pkg::*;
#(
  parameter int unsigned N_IRQ         = 8,
  parameter logic [13:0] VECTOR_BASE   = 14'h0010,
  parameter int unsigned VECTOR_STRIDE = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic [3:0]       control_state,
  input  logic             iret,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [N_IRQ-1:0] cfg_wdata,
  output logic [N_IRQ-1:0] cfg_rdata,
  output logic             interrupt,
  output logic [13:0]      interrupt_vector_address,
  output logic [3:0]       irq_active_id,
  output logic             in_service
);

  logic [N_IRQ-1:0] prev_q;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] enable_q;
  logic [N_IRQ-1:0] edge_sel_q;
  logic             global_q;

  irq_state_e       state_q;
  logic             interrupt_q;
  logic [13:0]      vector_q;
  logic [3:0]       id_q;
  logic             in_service_q;

  logic [N_IRQ-1:0] set_vec, clr_vec;
  logic             enc_valid, cand_valid;
  logic [3:0]       cand_idx;
  logic [13:0]      vec_calc;
  logic             accept;
  logic             active_live;

  irq_priority_encoder #(.N(N_IRQ)) u_prio (
    .req   (pending_q & enable_q),
    .valid (enc_valid),
    .index (cand_idx)
  );

  assign cand_valid = enc_valid & global_q;
  assign vec_calc   = VECTOR_BASE + 14'(cand_idx) * 14'(VECTOR_STRIDE);
  assign accept     = (state_q == ST_REQUEST) && (control_state == HCU_STATE_INTERRUPT);

  // Set terms are OR-ed after the clear mask so a new arrival always survives.
  always_comb begin
    set_vec = (edge_sel_q & irq_in & ~prev_q) | (~edge_sel_q & irq_in);
    clr_vec = '0;
    if (cfg_we && cfg_addr == CFG_ADDR_PENDING) clr_vec = cfg_wdata;
    for (int unsigned i = 0; i < N_IRQ; i++) begin
      if (accept && id_q == 4'(i)) clr_vec[i] = 1'b1;
    end
    pending_d = (pending_q & ~clr_vec) | set_vec;
  end

  always_comb begin
    active_live = 1'b0;
    for (int unsigned i = 0; i < N_IRQ; i++) begin
      if (id_q == 4'(i)) active_live = pending_q[i] & enable_q[i];
    end
    active_live = active_live & global_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_q     <= '0;
      pending_q  <= '0;
      enable_q   <= '0;
      edge_sel_q <= '0;
      global_q   <= 1'b0;
    end else begin
      prev_q    <= irq_in;
      pending_q <= pending_d;
      if (cfg_we) begin
        case (cfg_addr)
          CFG_ADDR_ENABLE:   enable_q   <= cfg_wdata;
          CFG_ADDR_EDGE_SEL: edge_sel_q <= cfg_wdata;
          CFG_ADDR_GLOBAL:   global_q   <= cfg_wdata[0];
          default: ;
        endcase
      end
    end
  end

  // Id and vector are captured on entry to REQUEST and held until a new selection.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      interrupt_q  <= 1'b0;
      vector_q     <= '0;
      id_q         <= '0;
      in_service_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cand_valid) begin
            state_q     <= ST_REQUEST;
            interrupt_q <= 1'b1;
            id_q        <= cand_idx;
            vector_q    <= vec_calc;
          end
        end
        ST_REQUEST: begin
          if (accept) begin
            state_q      <= ST_SERVICE;
            interrupt_q  <= 1'b0;
            in_service_q <= 1'b1;
          end else if (!active_live) begin
            state_q     <= ST_IDLE;
            interrupt_q <= 1'b0;
          end
        end
        ST_SERVICE: begin
          if (iret) begin
            state_q      <= ST_IDLE;
            in_service_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      CFG_ADDR_ENABLE:   cfg_rdata = enable_q;
      CFG_ADDR_PENDING:  cfg_rdata = pending_q;
      CFG_ADDR_EDGE_SEL: cfg_rdata = edge_sel_q;
      default:           cfg_rdata[0] = global_q;
    endcase
  end

  assign interrupt                = interrupt_q;
  assign interrupt_vector_address = vector_q;
  assign irq_active_id            = id_q;
  assign in_service               = in_service_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller with hand-computed expectations.
module tb_interrupt_controller;

  logic        clock;
  logic        reset;
  logic [7:0]  irq_in;
  logic [3:0]  control_state;
  logic        iret;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [7:0]  cfg_wdata;
  logic [7:0]  cfg_rdata;
  logic        interrupt;
  logic [13:0] interrupt_vector_address;
  logic [3:0]  irq_active_id;
  logic        in_service;

  int checks = 0;
  int errors = 0;

  interrupt_controller #(
    .N_IRQ(8),
    .VECTOR_BASE(14'h0010),
    .VECTOR_STRIDE(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .irq_in(irq_in),
    .control_state(control_state),
    .iret(iret),
    .cfg_we(cfg_we),
    .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata),
    .interrupt(interrupt),
    .interrupt_vector_address(interrupt_vector_address),
    .irq_active_id(irq_active_id),
    .in_service(in_service)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0; cfg_wdata = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++;
    if ({interrupt, interrupt_vector_address, irq_active_id, in_service} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs: got int=%0b vec=%h id=%0d isv=%0b, expected all 0",
               interrupt, interrupt_vector_address, irq_active_id, in_service);
    end
    for (int a = 0; a < 4; a++) begin
      cfg_addr = 2'(a); #1;
      checks++;
      if (cfg_rdata !== 8'h00) begin
        errors++; $display("FAIL reset_rdata addr %0d: got %h expected 00", a, cfg_rdata);
      end
    end
  endtask

  task automatic test_basic_edge();
    cfg_write(2'd0, 8'h01);
    cfg_write(2'd2, 8'h01);
    cfg_write(2'd3, 8'h01);
    irq_in = 8'h01; tick(); irq_in = 8'h00;
    checks++;
    if (interrupt !== 1'b0) begin
      errors++; $display("FAIL basic_latency1: got int=%0b expected 0", interrupt);
    end
    tick();
    checks++;
    if (interrupt !== 1'b1 || interrupt_vector_address !== 14'h0010 || irq_active_id !== 4'd0) begin
      errors++;
      $display("FAIL basic_request: got int=%0b vec=%h id=%0d expected 1/0010/0",
               interrupt, interrupt_vector_address, irq_active_id);
    end
    control_state = 4'h1; tick();
    checks++;
    if (interrupt !== 1'b1) begin
      errors++; $display("FAIL basic_held_stall: got int=%0b expected 1", interrupt);
    end
    control_state = 4'h2; tick(); control_state = 4'h0;
    cfg_addr = 2'd1; #1;
    checks++;
    if (interrupt !== 1'b0 || in_service !== 1'b1 || cfg_rdata !== 8'h00) begin
      errors++;
      $display("FAIL basic_accept: got int=%0b isv=%0b pend=%h expected 0/1/00",
               interrupt, in_service, cfg_rdata);
    end
    iret = 1'b1; tick(); iret = 1'b0;
    checks++;
    if (in_service !== 1'b0) begin
      errors++; $display("FAIL basic_iret: got isv=%0b expected 0", in_service);
    end
  endtask

  task automatic test_priority();
    cfg_write(2'd2, 8'h28);
    cfg_write(2'd0, 8'h28);
    irq_in = 8'h28; tick(); irq_in = 8'h00;
    tick();
    checks++;
    if (interrupt !== 1'b1 || irq_active_id !== 4'd3 || interrupt_vector_address !== 14'h001C) begin
      errors++;
      $display("FAIL prio_first: got int=%0b id=%0d vec=%h expected 1/3/001C",
               interrupt, irq_active_id, interrupt_vector_address);
    end
    control_state = 4'h2; tick(); control_state = 4'h0;
    iret = 1'b1; tick(); iret = 1'b0;
    tick();
    checks++;
    if (interrupt !== 1'b1 || irq_active_id !== 4'd5 || interrupt_vector_address !== 14'h0024) begin
      errors++;
      $display("FAIL prio_second: got int=%0b id=%0d vec=%h expected 1/5/0024",
               interrupt, irq_active_id, interrupt_vector_address);
    end
    control_state = 4'h2; tick(); control_state = 4'h0;
    iret = 1'b1; tick(); iret = 1'b0;
  endtask

  task automatic test_level_block();
    cfg_write(2'd2, 8'h00);
    cfg_write(2'd0, 8'h04);
    irq_in = 8'h04; tick(); tick();
    checks++;
    if (interrupt !== 1'b1 || irq_active_id !== 4'd2 || interrupt_vector_address !== 14'h0018) begin
      errors++;
      $display("FAIL level_request: got int=%0b id=%0d vec=%h expected 1/2/0018",
               interrupt, irq_active_id, interrupt_vector_address);
    end
    control_state = 4'h2; tick(); control_state = 4'h0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (interrupt !== 1'b0 || in_service !== 1'b1) begin
        errors++;
        $display("FAIL level_blocked cyc %0d: got int=%0b isv=%0b expected 0/1", c, interrupt, in_service);
      end
    end
    iret = 1'b1; tick(); iret = 1'b0;
    checks++;
    if (interrupt !== 1'b0) begin
      errors++; $display("FAIL level_iret_edge: got int=%0b expected 0", interrupt);
    end
    tick();
    checks++;
    if (interrupt !== 1'b1 || irq_active_id !== 4'd2) begin
      errors++; $display("FAIL level_rerequest: got int=%0b id=%0d expected 1/2", interrupt, irq_active_id);
    end
    irq_in = 8'h00; control_state = 4'h2; tick(); control_state = 4'h0;
    iret = 1'b1; tick(); iret = 1'b0;
  endtask

  task automatic test_withdraw();
    cfg_write(2'd2, 8'h10);
    cfg_write(2'd0, 8'h10);
    irq_in = 8'h10; tick(); irq_in = 8'h00; tick();
    checks++;
    if (interrupt !== 1'b1 || interrupt_vector_address !== 14'h0020) begin
      errors++;
      $display("FAIL withdraw_request: got int=%0b vec=%h expected 1/0020", interrupt, interrupt_vector_address);
    end
    cfg_write(2'd1, 8'h10);
    tick();
    checks++;
    if (interrupt !== 1'b0) begin
      errors++; $display("FAIL withdraw_drop: got int=%0b expected 0", interrupt);
    end
    control_state = 4'h2; tick(); control_state = 4'h0;
    checks++;
    if (in_service !== 1'b0 || interrupt !== 1'b0) begin
      errors++;
      $display("FAIL withdraw_ignore_accept: got isv=%0b int=%0b expected 0/0", in_service, interrupt);
    end
  endtask

  task automatic test_back_to_back();
    cfg_write(2'd2, 8'h02);
    cfg_write(2'd0, 8'h02);
    irq_in = 8'h02; tick(); irq_in = 8'h00; tick();
    checks++;
    if (interrupt !== 1'b1 || interrupt_vector_address !== 14'h0014) begin
      errors++;
      $display("FAIL b2b_request: got int=%0b vec=%h expected 1/0014", interrupt, interrupt_vector_address);
    end
    irq_in = 8'h02; control_state = 4'h2; tick();
    irq_in = 8'h00; control_state = 4'h0;
    cfg_addr = 2'd1; #1;
    checks++;
    if (in_service !== 1'b1 || cfg_rdata !== 8'h02) begin
      errors++;
      $display("FAIL b2b_set_wins: got isv=%0b pend=%h expected 1/02", in_service, cfg_rdata);
    end
    iret = 1'b1; tick(); iret = 1'b0; tick();
    checks++;
    if (interrupt !== 1'b1 || irq_active_id !== 4'd1) begin
      errors++; $display("FAIL b2b_rerequest: got int=%0b id=%0d expected 1/1", interrupt, irq_active_id);
    end
  endtask

  task automatic test_reset_midway();
    control_state = 4'h2; tick(); control_state = 4'h0;
    irq_in = 8'h02; tick(); irq_in = 8'h00;
    checks++;
    if (in_service !== 1'b1) begin
      errors++; $display("FAIL midreset_pre: got isv=%0b expected 1", in_service);
    end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++;
    if ({interrupt, interrupt_vector_address, irq_active_id, in_service} !== 20'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got int=%0b vec=%h id=%0d isv=%0b expected all 0",
               interrupt, interrupt_vector_address, irq_active_id, in_service);
    end
    for (int a = 0; a < 4; a++) begin
      cfg_addr = 2'(a); #1;
      checks++;
      if (cfg_rdata !== 8'h00) begin
        errors++; $display("FAIL midreset_rdata addr %0d: got %h expected 00", a, cfg_rdata);
      end
    end
    tick();
    checks++;
    if (interrupt !== 1'b0) begin
      errors++; $display("FAIL midreset_quiet: got int=%0b expected 0", interrupt);
    end
  endtask

  initial begin
    reset = 1'b1; irq_in = '0; control_state = '0; iret = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    test_reset();
    test_basic_edge();
    test_priority();
    test_level_block();
    test_withdraw();
    test_back_to_back();
    test_reset_midway();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
